l1_blk_arb8: RTL and testbench

Round-robin arbiter and sequencer for an 8-input, block-wide (`L1_BLOCK_SIZE`) L1 datapath. It grants one of eight requesters and steers that requester's block through an 8:1 select. The selected beat is captured into a registered output stage with a valid/ready handshake. Multi-beat bursts hold the grant until the final beat. The block sits between the L1 fill/writeback sources and the shared block bus into the L1 data array.

---
 rtl/l1_blk_arb8.sv | 144 ++++++++++++++
 tb/tb_l1_blk_arb8.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/l1_blk_arb8.sv
// Round-robin 8:1 block arbiter with a registered valid/ready output stage.
// Define L1_ARB_BURST_EN to let multi-beat bursts hold the grant until their last beat.
`ifndef L1_BLOCK_SIZE
`define L1_BLOCK_SIZE 512
`endif

module l1_blk_arb8 #(
  parameter int DATA_W = `L1_BLOCK_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req,
  input  logic [7:0]        last,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [7:0]        ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_src,
  output logic              out_last,
  input  logic              out_ready
);

  // Handshake: a beat moves downstream on any edge where out_valid & out_ready;
  // a requester's beat is taken on any edge where its ack bit is high.
  logic [DATA_W-1:0] in_arr [8];
  assign in_arr[0] = in0;
  assign in_arr[1] = in1;
  assign in_arr[2] = in2;
  assign in_arr[3] = in3;
  assign in_arr[4] = in4;
  assign in_arr[5] = in5;
  assign in_arr[6] = in6;
  assign in_arr[7] = in7;

  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        win_idx, scan_idx;
  logic              win_vld, load_en, capture;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [2:0]        out_src_q, out_src_d;
  logic              out_last_q, out_last_d;

`ifdef L1_ARB_BURST_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  logic [0:0] state_q, state_d;
  logic [2:0] owner_q, owner_d;
`endif

  // Winner: owner while locked in a burst, otherwise first request at or above ptr.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr_q;
    scan_idx = ptr_q;
`ifdef L1_ARB_BURST_EN
    if (state_q == ST_BURST) begin
      win_vld = req[owner_q];
      win_idx = owner_q;
    end else
`endif
    begin
      for (int k = 7; k >= 0; k--) begin
        scan_idx = ptr_q + 3'(k);
        if (req[scan_idx]) begin
          win_vld = 1'b1;
          win_idx = scan_idx;
        end
      end
    end
  end

  assign load_en = !out_valid_q || out_ready;
  assign capture = load_en && win_vld;

  always_comb begin
    ack = '0;
    if (capture && rst_n) ack[win_idx] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = load_en ? win_vld : out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
`ifdef L1_ARB_BURST_EN
    state_d     = state_q;
    owner_d     = owner_q;
`endif
    if (capture) begin
      out_data_d = in_arr[win_idx];
      out_src_d  = win_idx;
      out_last_d = last[win_idx];
`ifdef L1_ARB_BURST_EN
      if (last[win_idx]) begin
        state_d = ST_IDLE;
        ptr_d   = win_idx + 3'd1;
      end else if (state_q == ST_IDLE) begin
        state_d = ST_BURST;
        owner_d = win_idx;
      end
`else
      ptr_d = win_idx + 3'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      out_last_q  <= 1'b0;
`ifdef L1_ARB_BURST_EN
      state_q     <= ST_IDLE;
      owner_q     <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
`ifdef L1_ARB_BURST_EN
      state_q     <= state_d;
      owner_q     <= owner_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_l1_blk_arb8.sv
// Bench for l1_blk_arb8: vector table of ack expectations plus an output-beat queue.
// Burst-lock expectations follow L1_ARB_BURST_EN.
module tb_l1_blk_arb8;
  localparam int DW = 32;
  localparam int EW = DW + 4;

  logic          clk;
  logic          rst_n;
  logic [7:0]    req;
  logic [7:0]    last;
  logic [DW-1:0] tb_in [8];
  logic [7:0]    ack;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    out_src;
  logic          out_last;
  logic          out_ready;

  l1_blk_arb8 #(.DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last),
    .in0(tb_in[0]), .in1(tb_in[1]), .in2(tb_in[2]), .in3(tb_in[3]),
    .in4(tb_in[4]), .in5(tb_in[5]), .in6(tb_in[6]), .in7(tb_in[7]),
    .ack(ack), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_last(out_last), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [7:0] req;
    logic [7:0] last;
    logic       rdy;
    logic [7:0] ack;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [7:0] r, input logic [7:0] l, input logic rdy, input logic [7:0] a);
    vec_t v;
    v.req = r; v.last = l; v.rdy = rdy; v.ack = a;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver + scoreboard: drive one cycle, check ack, pop on accept, push on capture
  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic rdy, input logic [7:0] ea);
    logic [EW-1:0] item;
    int src;
    req = r;
    last = l;
    out_ready = rdy;
    for (int i = 0; i < 8; i++) tb_in[i] = {8'(i), 24'($urandom_range(24'hFFFFFF, 0))};
    @(negedge clk);
    chk("ack", ack, ea);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop: unexpected beat src=%0d data=%0h, required none", out_src, out_data);
      end else begin
        item = exp_q.pop_front();
        chk("beat", {out_src, out_last, out_data}, item);
      end
    end else if (out_valid && exp_q.size() > 0) begin
      chk("hold_data", out_data, exp_q[0][DW-1:0]);
    end
    if (ea != 8'h00) begin
      src = 0;
      for (int i = 0; i < 8; i++) if (ea[i]) src = i;
      exp_q.push_back({3'(src), l[src], tb_in[src]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_data"}, out_data, 0);
    chk({nm, "_src"}, out_src, 0);
    chk({nm, "_last"}, out_last, 0);
    chk({nm, "_ack"}, ack, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req = 8'h00;
    last = 8'h00;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) tb_in[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    req = 8'hFF;
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 8'h00, 1'b0, 8'h00);
      chk("idle_valid", out_valid, 0);
    end

    // round robin 0..7 then wrap to 0
    for (int i = 0; i < 9; i++) add(8'hFF, 8'hFF, 1'b1, 8'(1) << (i % 8));
    // wrap and skip: grant 6, then 0, then 6
    add(8'h40, 8'h40, 1'b1, 8'h40);
    add(8'h41, 8'h41, 1'b1, 8'h01);
    add(8'h41, 8'h41, 1'b1, 8'h40);
    add(8'h00, 8'h00, 1'b1, 8'h00);
    add(8'h00, 8'h00, 1'b1, 8'h00);
    // backpressure: capture into empty stage, hold 5 cycles, then pop+capture together
    add(8'h04, 8'h04, 1'b0, 8'h04);
    for (int i = 0; i < 5; i++) add(8'h08, 8'h08, 1'b0, 8'h00);
    add(8'h08, 8'h08, 1'b1, 8'h08);
    add(8'h00, 8'h00, 1'b1, 8'h00);
    // burst lock: grant 2 first so requester 3 is next ahead of 5
    add(8'h04, 8'h04, 1'b1, 8'h04);
`ifdef L1_ARB_BURST_EN
    add(8'h28, 8'h00, 1'b1, 8'h08);
    add(8'h28, 8'h00, 1'b1, 8'h08);
    add(8'h28, 8'h00, 1'b1, 8'h08);
    add(8'h28, 8'h08, 1'b1, 8'h08);
    add(8'h20, 8'h20, 1'b1, 8'h20);
    add(8'h00, 8'h00, 1'b1, 8'h00);
    // owner stalls: other requesters stay locked out
    add(8'h28, 8'h00, 1'b1, 8'h08);
    add(8'h20, 8'h00, 1'b1, 8'h00);
    add(8'h20, 8'h00, 1'b1, 8'h00);
    add(8'h28, 8'h08, 1'b1, 8'h08);
    add(8'h20, 8'h20, 1'b1, 8'h20);
    add(8'h00, 8'h00, 1'b1, 8'h00);
`else
    add(8'h28, 8'h00, 1'b1, 8'h08);
    add(8'h28, 8'h00, 1'b1, 8'h20);
    add(8'h28, 8'h00, 1'b1, 8'h08);
    add(8'h28, 8'h08, 1'b1, 8'h20);
    add(8'h20, 8'h20, 1'b1, 8'h20);
    add(8'h00, 8'h00, 1'b1, 8'h00);
`endif

    foreach (vecs[i]) step(vecs[i].req, vecs[i].last, vecs[i].rdy, vecs[i].ack);

    // reset while a beat is pending (mid-burst when bursts are enabled)
    step(8'h28, 8'h00, 1'b1, 8'h08);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // ptr back at 0 and not locked to 3: requester 5 wins alone
    step(8'h20, 8'h20, 1'b1, 8'h20);
    step(8'h00, 8'h00, 1'b1, 8'h00);
    step(8'h00, 8'h00, 1'b1, 8'h00);
    chk("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
